// File: rtl/strobe_counter_sequencer.sv
// Sequencer for one counter_with_strobe: gates ticks into the counter's enable, counts bursts of strobes.
// Optional STROBE_SEQ_OVERRUN_COUNT_EN adds a saturating dropped-tick counter output.
module strobe_counter_sequencer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned OVR_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   period,
  input  logic [BURST_W-1:0] burst,
  input  logic               tick_in,
  input  logic               upd_req,
  output logic               upd_ack,
  output logic               busy,
  output logic               done,
  output logic               strobe_out,
  output logic               cfg_err,
  output logic               overrun,
`ifdef STROBE_SEQ_OVERRUN_COUNT_EN
  output logic [OVR_W-1:0]   overrun_count,
`endif
  output logic               cnt_rst,
  output logic               cnt_enable,
  output logic [WIDTH-1:0]   cnt_reset_value,
  input  logic               cnt_strobe,
  input  logic               cnt_ready,
  input  logic               cnt_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic               en_q;
  logic               en_c;
  logic               free_run_q, free_run_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0]   rv_d;
  logic               overrun_d, upd_ack_d, done_d, strobe_d, cfg_err_d;
  logic               drop, start_ok, last, period_ok;
  logic               unused_valid;

  // cnt_valid carries no information the sequencer needs
  assign unused_valid = cnt_valid;
  assign period_ok    = (period >= WIDTH'(2));
  assign cnt_enable   = en_c;

  // Next-state, pending slot, burst accounting and period update
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    free_run_d  = free_run_q;
    remaining_d = remaining_q;
    rv_d        = cnt_reset_value;
    overrun_d   = overrun;
    upd_ack_d   = 1'b0;
    done_d      = 1'b0;
    strobe_d    = 1'b0;
    cfg_err_d   = 1'b0;
    en_c        = 1'b0;
    drop        = 1'b0;
    start_ok    = 1'b0;
    last        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (period_ok) begin
            state_d     = S_ARM;
            rv_d        = period;
            remaining_d = burst;
            free_run_d  = (burst == BURST_W'(0));
            overrun_d   = 1'b0;
            pending_d   = 1'b0;
            start_ok    = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        if (tick_in) begin
          drop      = pending_q;
          pending_d = 1'b1;
        end
        if (stop) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
        end else if (cnt_ready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Enable never on back-to-back cycles and only while the counter is ready
        en_c      = pending_q && cnt_ready && !en_q;
        pending_d = (pending_q && !en_c) || tick_in;
        drop      = tick_in && pending_q && !en_c;
        strobe_d  = cnt_strobe;
        last      = cnt_strobe && !free_run_q && (remaining_q == BURST_W'(1));
        if (cnt_strobe && !free_run_q && (remaining_q != BURST_W'(0)))
          remaining_d = remaining_q - BURST_W'(1);
        if (stop) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
        end else if (last) begin
          done_d    = 1'b1;
          state_d   = S_IDLE;
          pending_d = 1'b0;
        end else if (cnt_strobe && !en_c && upd_req) begin
          if (period_ok) begin
            rv_d      = period;
            upd_ack_d = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (drop) overrun_d = 1'b1;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pending_q       <= 1'b0;
      en_q            <= 1'b0;
      free_run_q      <= 1'b0;
      remaining_q     <= '0;
      cnt_reset_value <= WIDTH'(2);
      overrun         <= 1'b0;
      upd_ack         <= 1'b0;
      done            <= 1'b0;
      strobe_out      <= 1'b0;
      cfg_err         <= 1'b0;
      busy            <= 1'b0;
      cnt_rst         <= 1'b1;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      en_q            <= en_c;
      free_run_q      <= free_run_d;
      remaining_q     <= remaining_d;
      cnt_reset_value <= rv_d;
      overrun         <= overrun_d;
      upd_ack         <= upd_ack_d;
      done            <= done_d;
      strobe_out      <= strobe_d;
      cfg_err         <= cfg_err_d;
      busy            <= (state_d != S_IDLE);
      cnt_rst         <= (state_d == S_IDLE);
    end
  end

`ifdef STROBE_SEQ_OVERRUN_COUNT_EN
  // Saturating count of dropped ticks, cleared by an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun_count <= '0;
    else if (start_ok)
      overrun_count <= '0;
    else if (drop && (overrun_count != {OVR_W{1'b1}}))
      overrun_count <= overrun_count + OVR_W'(1);
  end
`endif

endmodule

// File: tb/tb_strobe_counter_sequencer.sv
// Directed bench for strobe_counter_sequencer; the counter side (ready/strobe) is driven from the vectors.
// Define STROBE_SEQ_OVERRUN_COUNT_EN to also check overrun_count.
module tb_strobe_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, tick_in = 1'b0, upd_req = 1'b0;
  logic [3:0] period = 4'd0;
  logic [7:0] burst = 8'd0;
  logic       cnt_strobe = 1'b0, cnt_ready = 1'b0, cnt_valid = 1'b0;
  logic       upd_ack, busy, done, strobe_out, cfg_err, overrun;
  logic       cnt_rst, cnt_enable;
  logic [3:0] cnt_reset_value;
`ifdef STROBE_SEQ_OVERRUN_COUNT_EN
  logic [7:0] overrun_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  strobe_counter_sequencer #(.WIDTH(4), .BURST_W(8), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .period(period), .burst(burst),
    .tick_in(tick_in), .upd_req(upd_req), .upd_ack(upd_ack), .busy(busy), .done(done),
    .strobe_out(strobe_out), .cfg_err(cfg_err), .overrun(overrun),
`ifdef STROBE_SEQ_OVERRUN_COUNT_EN
    .overrun_count(overrun_count),
`endif
    .cnt_rst(cnt_rst), .cnt_enable(cnt_enable), .cnt_reset_value(cnt_reset_value),
    .cnt_strobe(cnt_strobe), .cnt_ready(cnt_ready), .cnt_valid(cnt_valid)
  );

  // flags = {busy, done, strobe_out, cfg_err, overrun, cnt_rst, upd_ack}
  typedef struct {
    logic       st, sp;
    logic [3:0] p;
    logic [7:0] b;
    logic       tk, ur, cs, cr;
    logic       en;
    logic [6:0] flags;
    logic [3:0] rv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic [3:0] p,
                              input logic [7:0] b, input logic tk, input logic ur,
                              input logic cs, input logic cr, input logic en,
                              input logic [6:0] flags, input logic [3:0] rv);
    vec_t v;
    v.st = st; v.sp = sp; v.p = p; v.b = b; v.tk = tk; v.ur = ur; v.cs = cs; v.cr = cr;
    v.en = en; v.flags = flags; v.rv = rv;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {busy, done, strobe_out, cfg_err, overrun, cnt_rst, upd_ack, cnt_reset_value};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    start = v.st; stop = v.sp; period = v.p; burst = v.b;
    tick_in = v.tk; upd_req = v.ur; cnt_strobe = v.cs; cnt_ready = v.cr;
  endtask

  task automatic drive(input logic st, input logic sp, input logic [3:0] p, input logic [7:0] b,
                       input logic tk, input logic cs, input logic cr);
    apply(mk(st, sp, p, b, tk, 1'b0, cs, cr, 1'b0, 7'd0, 4'd0));
  endtask

  task automatic step_to_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_cnt;
    logic prev_en, back2back;

    // st sp  p  b   tk ur cs cr | en | flags | rv
    vq.push_back(mk(1,0,4'd3,8'd2, 0,0,0,0, 0, 7'b1000000, 4'd3)); // start p=3 burst=2
    vq.push_back(mk(0,0,4'd0,8'd0, 1,0,0,0, 0, 7'b1000000, 4'd3)); // tick held in ARM
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 0, 7'b1000000, 4'd3)); // ready -> RUN
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 1, 7'b1000000, 4'd3)); // pending consumed
    vq.push_back(mk(0,0,4'd0,8'd0, 1,0,0,1, 0, 7'b1000000, 4'd3));
    vq.push_back(mk(0,0,4'd0,8'd0, 1,0,0,1, 1, 7'b1000000, 4'd3)); // consume + refill
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 0, 7'b1000000, 4'd3)); // no back-to-back enable
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,0, 0, 7'b1000000, 4'd3)); // not ready
    vq.push_back(mk(0,0,4'd0,8'd0, 1,0,0,1, 1, 7'b1000000, 4'd3));
    vq.push_back(mk(0,0,4'd0,8'd0, 1,0,0,1, 0, 7'b1000100, 4'd3)); // dropped tick
    vq.push_back(mk(0,0,4'd6,8'd0, 0,1,1,1, 1, 7'b1010100, 4'd3)); // strobe with enable: no update
    vq.push_back(mk(0,0,4'd6,8'd0, 0,1,1,1, 0, 7'b0110110, 4'd3)); // 2nd strobe: done
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,0, 0, 7'b0000110, 4'd3));
    vq.push_back(mk(1,0,4'd1,8'd0, 0,0,0,0, 0, 7'b0001110, 4'd3)); // period<2 rejected
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,0, 0, 7'b0000110, 4'd3));
    vq.push_back(mk(1,1,4'd5,8'd0, 0,0,0,0, 0, 7'b0000110, 4'd3)); // start+stop: stop wins
    vq.push_back(mk(1,0,4'd4,8'd0, 0,0,0,0, 0, 7'b1000000, 4'd4)); // free-run p=4
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 0, 7'b1000000, 4'd4));
    vq.push_back(mk(0,0,4'd0,8'd0, 1,0,0,1, 0, 7'b1000000, 4'd4));
    vq.push_back(mk(0,0,4'd6,8'd0, 0,1,1,1, 1, 7'b1010000, 4'd4)); // enable blocks update
    vq.push_back(mk(0,0,4'd1,8'd0, 0,1,1,1, 0, 7'b1011000, 4'd4)); // bad period update
    vq.push_back(mk(0,0,4'd6,8'd0, 0,1,1,1, 0, 7'b1010001, 4'd6)); // update acked
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 0, 7'b1000000, 4'd6));
    vq.push_back(mk(1,1,4'd5,8'd0, 1,0,1,1, 0, 7'b0010010, 4'd6)); // stop with strobe
    vq.push_back(mk(0,1,4'd0,8'd0, 0,0,0,0, 0, 7'b0000010, 4'd6)); // stop in IDLE
    vq.push_back(mk(1,0,4'd2,8'd3, 0,0,0,0, 0, 7'b1000000, 4'd2)); // burst=3
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 0, 7'b1000000, 4'd2));
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,1,1, 0, 7'b1010000, 4'd2));
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,1,1, 0, 7'b1010000, 4'd2));
    vq.push_back(mk(0,1,4'd0,8'd0, 0,0,0,1, 0, 7'b0000010, 4'd2)); // stop: no done
    vq.push_back(mk(1,0,4'd2,8'd1, 0,0,0,0, 0, 7'b1000000, 4'd2)); // restart p=2 burst=1
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 0, 7'b1000000, 4'd2));
    vq.push_back(mk(0,0,4'd0,8'd0, 1,0,0,1, 0, 7'b1000000, 4'd2));
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,0,1, 1, 7'b1000000, 4'd2));
    vq.push_back(mk(0,0,4'd0,8'd0, 0,0,1,1, 0, 7'b0110010, 4'd2)); // single strobe: done

    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'({7'b0000010, 4'd2}));
    check("reset_en", 32'(cnt_enable), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      apply(vq[i]);
      #1;
      check($sformatf("v%0d_en", i), 32'(cnt_enable), 32'(vq[i].en));
      step_to_edge();
      check($sformatf("v%0d_outs", i), 32'(outs()), 32'({vq[i].flags, vq[i].rv}));
    end

    // Free-run, tick held high for 20 cycles with the counter always ready
    @(negedge clk); drive(1, 0, 4'd5, 8'd0, 0, 0, 0); step_to_edge();
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 0, 0, 1); step_to_edge();
    en_cnt = 0; prev_en = 1'b0; back2back = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      drive(0, 0, 4'd0, 8'd0, 1, (c == 10) ? 1'b1 : 1'b0, 1);
      #1;
      if (cnt_enable) en_cnt++;
      if (cnt_enable && prev_en) back2back = 1'b1;
      prev_en = cnt_enable;
      step_to_edge();
      if (c == 10) check("fr_strobe_fwd", 32'(strobe_out), 32'(1'b1));
    end
    check("fr_no_back2back", 32'(back2back), 32'(1'b0));
    check("fr_en_count", 32'(en_cnt), 32'd10);
    check("fr_overrun", 32'(overrun), 32'(1'b1));
    check("fr_busy", 32'(busy), 32'(1'b1));
`ifdef STROBE_SEQ_OVERRUN_COUNT_EN
    check("fr_overrun_count", 32'(overrun_count), 32'd9);
`endif
    @(negedge clk); drive(0, 1, 4'd0, 8'd0, 0, 0, 1); step_to_edge();
    check("fr_stop_idle", 32'({busy, cnt_rst, overrun}), 32'(3'b011));

    // Stop while waiting in ARM
    @(negedge clk); drive(1, 0, 4'd3, 8'd1, 0, 0, 0); step_to_edge();
    check("arm_busy", 32'({busy, cnt_rst, overrun}), 32'(3'b100));
`ifdef STROBE_SEQ_OVERRUN_COUNT_EN
    check("arm_count_cleared", 32'(overrun_count), 32'd0);
`endif
    @(negedge clk); drive(0, 1, 4'd0, 8'd0, 0, 0, 0); step_to_edge();
    check("arm_stop", 32'({busy, cnt_rst, done}), 32'(3'b010));

    // Async reset in RUN with a pending tick
    @(negedge clk); drive(1, 0, 4'd3, 8'd2, 0, 0, 0); step_to_edge();
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 0, 0, 1); step_to_edge();
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 1, 0, 0); step_to_edge();
    check("rr_running", 32'({busy, cnt_rst}), 32'(2'b10));
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("rr_async_outs", 32'(outs()), 32'({7'b0000010, 4'd2}));
    check("rr_async_en", 32'(cnt_enable), 32'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); drive(1, 0, 4'd3, 8'd2, 0, 0, 0); #1;
    check("rr_c0_en", 32'(cnt_enable), 32'(1'b0)); step_to_edge();
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 1, 0, 0); #1;
    check("rr_c1_en", 32'(cnt_enable), 32'(1'b0)); step_to_edge();
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 0, 0, 0); #1;
    check("rr_c2_en", 32'(cnt_enable), 32'(1'b0)); step_to_edge();
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 0, 0, 1); #1;
    check("rr_c3_en", 32'(cnt_enable), 32'(1'b0)); step_to_edge();
    @(negedge clk); drive(0, 0, 4'd0, 8'd0, 0, 0, 1); #1;
    check("rr_c4_en", 32'(cnt_enable), 32'(1'b1)); step_to_edge();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
